// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared types and constants for the fetch sequencer
package seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_WAIT   = 3'd2,
        S_ISSUE  = 3'd3,
        S_EXEC   = 3'd4,
        S_HALTED = 3'd5
    } seq_state_t;

    localparam logic [7:0] HALT_OP_DEFAULT = 8'hFF;

    localparam int ROM_LAT_MIN = 1;
    localparam int ROM_LAT_MAX = 4;

    // Wide enough to hold ROM_LAT_MAX
    localparam int WAIT_CTR_W = $clog2(ROM_LAT_MAX + 1);

    // Keeps an out-of-range latency parameter inside the supported window
    function automatic int clamp_rom_lat(input int lat);
        if (lat < ROM_LAT_MIN) begin
            return ROM_LAT_MIN;
        end
        if (lat > ROM_LAT_MAX) begin
            return ROM_LAT_MAX;
        end
        return lat;
    endfunction

endpackage

// File: rtl/rom_wait_ctr.sv
// rtl/rom_wait_ctr.sv - loadable down-counter timing the ROM read latency
module rom_wait_ctr
    import seq_pkg::*;
#(
    parameter int W = WAIT_CTR_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         tc
);

    logic [W-1:0] count;

    // Load takes priority; decrement stops at zero so a stray dec cannot wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    // Terminal count marks the last wait cycle, when ROM data is valid
    assign tc = (count == W'(1));

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - fetch/issue sequencer; FETCH_SEQ_BREAKPOINT_EN adds bp_en/bp_addr/bp_hit
module fetch_sequencer
    import seq_pkg::*;
#(
    parameter int                 ADDR_W  = 2,
    parameter int                 INSTR_W = 8,
    parameter int                 ROM_LAT = 1,
    parameter logic [INSTR_W-1:0] HALT_OP = INSTR_W'(HALT_OP_DEFAULT)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run,
    input  logic               step,
    input  logic               halt_req,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [INSTR_W-1:0] rom_data,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    input  logic               exec_done,
    output logic [ADDR_W-1:0]  pc,
    output logic               busy,
    output logic               halted
`ifdef FETCH_SEQ_BREAKPOINT_EN
    ,
    input  logic               bp_en,
    input  logic [ADDR_W-1:0]  bp_addr,
    output logic               bp_hit
`endif
);

    localparam int                    LAT      = clamp_rom_lat(ROM_LAT);
    localparam logic [WAIT_CTR_W-1:0] LAT_LOAD = WAIT_CTR_W'(LAT);

    seq_state_t        state;
    seq_state_t        next_state;
    logic              single;
    logic              wait_tc;
    logic              bp_take;
    logic [ADDR_W-1:0] pc_next;

    logic              instr_valid_nxt;
    logic              busy_nxt;
    logic              halted_nxt;

    assign pc_next = pc + ADDR_W'(1);

    rom_wait_ctr #(
        .W(WAIT_CTR_W)
    ) u_wait_ctr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (state == S_FETCH),
        .load_val (LAT_LOAD),
        .dec      (state == S_WAIT),
        .tc       (wait_tc)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; step beats run, halt_req only gates new starts and retire
    always_comb begin
        next_state = state;
        bp_take    = 1'b0;
        case (state)
            S_IDLE: begin
                if (step) begin
                    next_state = S_FETCH;
                end else if (run && !halt_req) begin
                    next_state = S_FETCH;
                end
            end
            S_FETCH: next_state = S_WAIT;
            S_WAIT: begin
                if (wait_tc) begin
                    next_state = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (instr == HALT_OP) begin
                    next_state = S_HALTED;
                end else begin
                    next_state = S_EXEC;
                end
            end
            S_EXEC: begin
                if (exec_done) begin
                    if (single || halt_req || !run) begin
                        next_state = S_IDLE;
`ifdef FETCH_SEQ_BREAKPOINT_EN
                    end else if (bp_en && (pc_next == bp_addr)) begin
                        next_state = S_IDLE;
                        bp_take    = 1'b1;
`endif
                    end else begin
                        next_state = S_FETCH;
                    end
                end
            end
            S_HALTED: next_state = S_HALTED;
            default:  next_state = S_IDLE;
        endcase
    end

    // Output decode from the upcoming state so the flops below present it aligned with state
    always_comb begin
        instr_valid_nxt = (next_state == S_ISSUE);
        busy_nxt        = (next_state != S_IDLE) && (next_state != S_HALTED);
        halted_nxt      = (next_state == S_HALTED);
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= '0;
            rom_addr    <= '0;
            instr       <= '0;
            single      <= 1'b0;
            instr_valid <= 1'b0;
            busy        <= 1'b0;
            halted      <= 1'b0;
        end else begin
            if ((state == S_IDLE) && (next_state == S_FETCH)) begin
                single <= step;
            end
            if ((state == S_WAIT) && wait_tc) begin
                instr <= rom_data;
            end
            if ((state == S_EXEC) && exec_done) begin
                pc       <= pc_next;
                rom_addr <= pc_next;
            end
            instr_valid <= instr_valid_nxt;
            busy        <= busy_nxt;
            halted      <= halted_nxt;
        end
    end

`ifdef FETCH_SEQ_BREAKPOINT_EN
    // One-cycle breakpoint pulse, coincident with the IDLE it causes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bp_hit <= 1'b0;
        end else begin
            bp_hit <= bp_take;
        end
    end
`else
    // Breakpoint logic absent: bp_take is constant low and has no sink
    logic unused_bp;
    assign unused_bp = bp_take;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed self-checking bench for fetch_sequencer
module tb_fetch_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       run = 1'b0;
    logic       step = 1'b0;
    logic       halt_req = 1'b0;
    logic [1:0] rom_addr;
    logic [7:0] rom_data = 8'h00;
    logic [7:0] instr;
    logic       instr_valid;
    logic       exec_done = 1'b0;
    logic [1:0] pc;
    logic       busy;
    logic       halted;
`ifdef FETCH_SEQ_BREAKPOINT_EN
    logic       bp_en = 1'b0;
    logic [1:0] bp_addr = 2'd0;
    logic       bp_hit;
    int         bp_cnt = 0;
`endif

    logic [7:0] mem [4];
    logic       ack_en = 1'b1;
    logic       pend = 1'b0;
    int         issue_cnt = 0;
    int         checks = 0;
    int         errors = 0;

    fetch_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run),
        .step        (step),
        .halt_req    (halt_req),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .instr       (instr),
        .instr_valid (instr_valid),
        .exec_done   (exec_done),
        .pc          (pc),
        .busy        (busy),
        .halted      (halted)
`ifdef FETCH_SEQ_BREAKPOINT_EN
        ,
        .bp_en       (bp_en),
        .bp_addr     (bp_addr),
        .bp_hit      (bp_hit)
`endif
    );

    always #5 clk = ~clk;

    // ROM model with one cycle of read latency
    always @(posedge clk) begin
        rom_data <= mem[rom_addr];
    end

    // Processor model: retire pulse in the cycle after each issue strobe
    initial begin
        forever begin
            @(posedge clk);
            #1;
            exec_done = ack_en && pend;
            pend = instr_valid;
        end
    end

    // Issue and breakpoint counters
    always @(posedge clk) begin
        if (rst_n && instr_valid) issue_cnt++;
`ifdef FETCH_SEQ_BREAKPOINT_EN
        if (rst_n && bp_hit) bp_cnt++;
`endif
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic load_rom(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
        mem[0] = a;
        mem[1] = b;
        mem[2] = c;
        mem[3] = d;
    endtask

    task automatic pulse_step();
        step = 1'b1;
        tick();
        step = 1'b0;
    endtask

    task automatic expect_issue(input string tag, input logic [7:0] e_instr, input logic [1:0] e_pc);
        int n = 0;
        while (!instr_valid && n < 30) begin
            tick();
            n++;
        end
        check_eq({tag, "_strobe"}, 32'(instr_valid), 32'd1);
        check_eq({tag, "_instr"}, 32'(instr), 32'(e_instr));
        check_eq({tag, "_pc"}, 32'(pc), 32'(e_pc));
        tick();
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 30) begin
            tick();
            n++;
        end
        check_eq({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int snap;

        // Reset values
        load_rom(8'h12, 8'h34, 8'h56, 8'h78);
        do_reset();
        check_eq("rst_pc", 32'(pc), 32'd0);
        check_eq("rst_rom_addr", 32'(rom_addr), 32'd0);
        check_eq("rst_instr", 32'(instr), 32'd0);
        check_eq("rst_valid", 32'(instr_valid), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_halted", 32'(halted), 32'd0);

        // Single step: strobe in the third cycle after the pulse
        pulse_step();
        check_eq("step_c1_busy", 32'(busy), 32'd1);
        check_eq("step_c1_valid", 32'(instr_valid), 32'd0);
        tick();
        check_eq("step_c2_valid", 32'(instr_valid), 32'd0);
        tick();
        check_eq("step_c3_valid", 32'(instr_valid), 32'd1);
        check_eq("step_c3_instr", 32'(instr), 32'h12);
        tick();
        check_eq("step_exec_busy", 32'(busy), 32'd1);
        tick();
        check_eq("step_done_pc", 32'(pc), 32'd1);
        check_eq("step_done_rom_addr", 32'(rom_addr), 32'd1);
        check_eq("step_done_busy", 32'(busy), 32'd0);
        tick();
        tick();
        check_eq("step_no_rerun", 32'(busy), 32'd0);

        // Free run with pc wrap
        load_rom(8'h01, 8'h02, 8'h03, 8'h04);
        do_reset();
        run = 1'b1;
        expect_issue("run0", 8'h01, 2'd0);
        expect_issue("run1", 8'h02, 2'd1);
        expect_issue("run2", 8'h03, 2'd2);
        expect_issue("run3", 8'h04, 2'd3);
        expect_issue("run4_wrap", 8'h01, 2'd0);
        run = 1'b0;
        wait_idle("run_stop");
        check_eq("run_stop_pc", 32'(pc), 32'd1);

        // Halt opcode is absorbing
        load_rom(8'h01, 8'h02, 8'hFF, 8'h04);
        do_reset();
        run = 1'b1;
        expect_issue("h0", 8'h01, 2'd0);
        expect_issue("h1", 8'h02, 2'd1);
        expect_issue("h2", 8'hFF, 2'd2);
        tick();
        tick();
        check_eq("halt_flag", 32'(halted), 32'd1);
        check_eq("halt_pc", 32'(pc), 32'd2);
        check_eq("halt_busy", 32'(busy), 32'd0);
        snap = issue_cnt;
        pulse_step();
        for (int i = 0; i < 8; i++) tick();
        check_eq("halt_no_issue", 32'(issue_cnt), 32'(snap));
        check_eq("halt_sticky", 32'(halted), 32'd1);
        check_eq("halt_pc_sticky", 32'(pc), 32'd2);
        run = 1'b0;
        do_reset();
        check_eq("halt_cleared", 32'(halted), 32'd0);
        check_eq("halt_clr_pc", 32'(pc), 32'd0);

        // halt_req raised during WAIT of address 1
        load_rom(8'h01, 8'h02, 8'h03, 8'h04);
        do_reset();
        run = 1'b1;
        expect_issue("hr0", 8'h01, 2'd0);
        tick();
        tick();
        halt_req = 1'b1;
        expect_issue("hr1", 8'h02, 2'd1);
        wait_idle("hr");
        check_eq("hr_pc", 32'(pc), 32'd2);
        snap = issue_cnt;
        for (int i = 0; i < 6; i++) tick();
        check_eq("hr_stays_idle", 32'(issue_cnt), 32'(snap));
        check_eq("hr_not_halted", 32'(halted), 32'd0);
        run = 1'b0;
        halt_req = 1'b0;

        // Asynchronous reset during EXEC
        do_reset();
        pulse_step();
        expect_issue("ar0", 8'h01, 2'd0);
        wait_idle("ar0");
        ack_en = 1'b0;
        pulse_step();
        expect_issue("ar1", 8'h02, 2'd1);
        check_eq("ar_in_exec", 32'(busy), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("ar_pc", 32'(pc), 32'd0);
        check_eq("ar_rom_addr", 32'(rom_addr), 32'd0);
        check_eq("ar_instr", 32'(instr), 32'd0);
        check_eq("ar_busy", 32'(busy), 32'd0);
        check_eq("ar_valid", 32'(instr_valid), 32'd0);
        check_eq("ar_halted", 32'(halted), 32'd0);
        tick();
        rst_n = 1'b1;
        ack_en = 1'b1;
        tick();

`ifdef FETCH_SEQ_BREAKPOINT_EN
        // Breakpoint at address 2
        begin
            int n = 0;
            do_reset();
            bp_addr = 2'd2;
            bp_en = 1'b1;
            bp_cnt = 0;
            run = 1'b1;
            expect_issue("bp0", 8'h01, 2'd0);
            expect_issue("bp1", 8'h02, 2'd1);
            while (!bp_hit && n < 30) begin
                tick();
                n++;
            end
            check_eq("bp_hit", 32'(bp_hit), 32'd1);
            check_eq("bp_busy", 32'(busy), 32'd0);
            check_eq("bp_pc", 32'(pc), 32'd2);
            tick();
            check_eq("bp_pulse_len", 32'(bp_hit), 32'd0);
            expect_issue("bp2", 8'h03, 2'd2);
            run = 1'b0;
            wait_idle("bp");
            check_eq("bp_single_hit", 32'(bp_cnt), 32'd1);
            bp_en = 1'b0;
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
